tex_bilinear_seq: RTL and testbench

Fragment-side texture sampler sequencer that sits directly upstream of the texture cache. It accepts one texture sample request per fragment (normalized s/t, one-texel step, 8-bit bilinear fractions) and issues one or four serialized lookups on the cache's `texture_s_i`/`texture_t_i`/`texture_lkp_i` port. It collects the returned 24-bit RGB texels from `texture_o`/`texture_valid_o`, blends them, and presents a tagged filtered colour to the fragment pipeline over a valid/ready handshake.

---
 rtl/tex_bilinear_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_tex_bilinear_seq.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tex_bilinear_seq.sv
// Texture sample sequencer: issues one or four serialized cache lookups per
// fragment, collects the returned texels and bilinearly blends them.
module tex_bilinear_seq (
    input  logic        core_clock_i,
    input  logic        core_reset_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [23:0] req_s_i,
    input  logic [23:0] req_t_i,
    input  logic [23:0] req_ds_i,
    input  logic [23:0] req_dt_i,
    input  logic [7:0]  req_fs_i,
    input  logic [7:0]  req_ft_i,
    input  logic        req_filter_i,
    input  logic [15:0] req_tag_i,
    output logic [23:0] tex_s_o,
    output logic [23:0] tex_t_o,
    output logic        tex_lkp_o,
    input  logic [23:0] tex_rgb_i,
    input  logic        tex_valid_i,
    output logic        frag_valid_o,
    input  logic        frag_ready_i,
    output logic [23:0] frag_rgb_o,
    output logic [15:0] frag_tag_o
);

    localparam int unsigned CW   = 24;
    localparam int unsigned FW   = 8;
    localparam int unsigned TAGW = 16;
    localparam int unsigned RGBW = 24;
    localparam int unsigned NCH  = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_BLEND_H = 3'd3,
        S_BLEND_V = 3'd4,
        S_OUT     = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CW-1:0]      r_s;
    logic [CW-1:0]      r_t;
    logic [CW-1:0]      r_ds;
    logic [CW-1:0]      r_dt;
    logic [FW-1:0]      r_fs;
    logic [FW-1:0]      r_ft;
    logic               r_filter;
    logic [TAGW-1:0]    r_tag;
    logic [1:0]         r_idx;
    logic [RGBW-1:0]    r_texel [4];
    logic [RGBW-1:0]    r_top;
    logic [RGBW-1:0]    r_bot;

    logic               r_req_ready;
    logic               r_lkp;
    logic               r_frag_valid;
    logic [CW-1:0]      r_tex_s;
    logic [CW-1:0]      r_tex_t;
    logic [RGBW-1:0]    r_frag_rgb;
    logic [TAGW-1:0]    r_frag_tag;

    logic               w_req_ready_nxt;
    logic               w_lkp_nxt;
    logic               w_frag_valid_nxt;
    logic [1:0]         w_coord_idx;
    logic [CW-1:0]      w_base_s;
    logic [CW-1:0]      w_base_t;
    logic [CW-1:0]      w_step_s;
    logic [CW-1:0]      w_step_t;
    logic [CW-1:0]      w_s_nxt;
    logic [CW-1:0]      w_t_nxt;
    logic [RGBW-1:0]    w_top;
    logic [RGBW-1:0]    w_bot;
    logic [RGBW-1:0]    w_vert;

    // 8-bit lerp with 9-bit weights; the sum never exceeds 255*256 so 16 bits suffice
    function automatic logic [7:0] lerp8(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] f);
        logic [15:0] w_p0;
        logic [15:0] w_p1;
        logic [15:0] w_sum;
        w_p0  = 16'(a) * (16'd256 - 16'(f));
        w_p1  = 16'(b) * 16'(f);
        w_sum = w_p0 + w_p1;
        return 8'(w_sum >> 8);
    endfunction

    // State register
    always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (req_valid_i) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (tex_valid_i) begin
                    if (!r_filter)           w_state_nxt = S_OUT;
                    else if (r_idx == 2'd3)  w_state_nxt = S_BLEND_H;
                    else                     w_state_nxt = S_ISSUE;
                end
            end
            S_BLEND_H: w_state_nxt = S_BLEND_V;
            S_BLEND_V: w_state_nxt = S_OUT;
            S_OUT:     if (frag_ready_i) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: next-cycle control outputs and the coordinate of the next lookup
    always_comb begin
        w_req_ready_nxt  = (w_state_nxt == S_IDLE);
        w_lkp_nxt        = (w_state_nxt == S_ISSUE);
        w_frag_valid_nxt = (w_state_nxt == S_OUT);
        w_coord_idx      = (r_state == S_IDLE) ? 2'd0 : r_idx + 2'd1;
        w_base_s         = (r_state == S_IDLE) ? req_s_i  : r_s;
        w_base_t         = (r_state == S_IDLE) ? req_t_i  : r_t;
        w_step_s         = (r_state == S_IDLE) ? req_ds_i : r_ds;
        w_step_t         = (r_state == S_IDLE) ? req_dt_i : r_dt;
        w_s_nxt          = w_base_s + (w_coord_idx[0] ? w_step_s : CW'(0));
        w_t_nxt          = w_base_t + (w_coord_idx[1] ? w_step_t : CW'(0));
    end

    // Per-channel horizontal and vertical blend
    always_comb begin
        w_top  = '0;
        w_bot  = '0;
        w_vert = '0;
        for (int ch = 0; ch < int'(NCH); ch++) begin
            w_top[ch*8 +: 8]  = lerp8(r_texel[0][ch*8 +: 8], r_texel[1][ch*8 +: 8], r_fs);
            w_bot[ch*8 +: 8]  = lerp8(r_texel[2][ch*8 +: 8], r_texel[3][ch*8 +: 8], r_fs);
            w_vert[ch*8 +: 8] = lerp8(r_top[ch*8 +: 8], r_bot[ch*8 +: 8], r_ft);
        end
    end

    // Registered handshake and lookup strobes
    always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            r_req_ready  <= 1'b1;
            r_lkp        <= 1'b0;
            r_frag_valid <= 1'b0;
        end else begin
            r_req_ready  <= w_req_ready_nxt;
            r_lkp        <= w_lkp_nxt;
            r_frag_valid <= w_frag_valid_nxt;
        end
    end

    // Request capture, texel collection, blend pipeline and result registers
    always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            r_s        <= '0;
            r_t        <= '0;
            r_ds       <= '0;
            r_dt       <= '0;
            r_fs       <= '0;
            r_ft       <= '0;
            r_filter   <= 1'b0;
            r_tag      <= '0;
            r_idx      <= 2'd0;
            for (int i = 0; i < 4; i++) r_texel[i] <= '0;
            r_top      <= '0;
            r_bot      <= '0;
            r_tex_s    <= '0;
            r_tex_t    <= '0;
            r_frag_rgb <= '0;
            r_frag_tag <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_s      <= req_s_i;
                        r_t      <= req_t_i;
                        r_ds     <= req_ds_i;
                        r_dt     <= req_dt_i;
                        r_fs     <= req_fs_i;
                        r_ft     <= req_ft_i;
                        r_filter <= req_filter_i;
                        r_tag    <= req_tag_i;
                        r_idx    <= 2'd0;
                    end
                end
                S_WAIT: begin
                    if (tex_valid_i) begin
                        r_texel[r_idx] <= tex_rgb_i;
                        if (!r_filter)           r_frag_rgb <= tex_rgb_i;
                        else if (r_idx != 2'd3)  r_idx      <= r_idx + 2'd1;
                    end
                end
                S_BLEND_H: begin
                    r_top <= w_top;
                    r_bot <= w_bot;
                end
                S_BLEND_V: r_frag_rgb <= w_vert;
                default: ;
            endcase
            if (w_state_nxt == S_ISSUE) begin
                r_tex_s <= w_s_nxt;
                r_tex_t <= w_t_nxt;
            end
            if ((w_state_nxt == S_OUT) && (r_state != S_OUT)) begin
                r_frag_tag <= r_tag;
            end
        end
    end

    assign req_ready_o  = r_req_ready;
    assign tex_lkp_o    = r_lkp;
    assign tex_s_o      = r_tex_s;
    assign tex_t_o      = r_tex_t;
    assign frag_valid_o = r_frag_valid;
    assign frag_rgb_o   = r_frag_rgb;
    assign frag_tag_o   = r_frag_tag;

endmodule

// File: tb/tb_tex_bilinear_seq.sv
// Self-checking bench for tex_bilinear_seq with a behavioural texture cache.
module tb_tex_bilinear_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready_o;
    logic [23:0] req_s, req_t, req_ds, req_dt;
    logic [7:0]  req_fs, req_ft;
    logic        req_filter;
    logic [15:0] req_tag;
    logic [23:0] tex_s_o, tex_t_o;
    logic        tex_lkp_o;
    logic [23:0] resp_rgb;
    logic        resp_valid;
    logic        spur_valid;
    logic        tex_valid;
    logic        frag_valid_o;
    logic        frag_ready;
    logic [23:0] frag_rgb_o;
    logic [15:0] frag_tag_o;

    int n_vec = 0;
    int n_err = 0;

    assign tex_valid = resp_valid | spur_valid;

    tex_bilinear_seq dut (
        .core_clock_i   (clk),
        .core_reset_n_i (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready_o),
        .req_s_i        (req_s),
        .req_t_i        (req_t),
        .req_ds_i       (req_ds),
        .req_dt_i       (req_dt),
        .req_fs_i       (req_fs),
        .req_ft_i       (req_ft),
        .req_filter_i   (req_filter),
        .req_tag_i      (req_tag),
        .tex_s_o        (tex_s_o),
        .tex_t_o        (tex_t_o),
        .tex_lkp_o      (tex_lkp_o),
        .tex_rgb_i      (resp_rgb),
        .tex_valid_i    (tex_valid),
        .frag_valid_o   (frag_valid_o),
        .frag_ready_i   (frag_ready),
        .frag_rgb_o     (frag_rgb_o),
        .frag_tag_o     (frag_tag_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int lkp_cnt = 0;
    always @(negedge clk) if (tex_lkp_o === 1'b1) lkp_cnt = lkp_cnt + 1;

    // Cache model state
    logic [23:0] lkp_s_q[$];
    logic [23:0] lkp_t_q[$];
    int          cfg_delay = 3;
    bit          tbl_mode = 1'b0;
    logic [23:0] tbl [4];
    int          tbl_base = 0;
    int          last_tv_cyc = 0;

    // Deterministic texture content as a function of the coordinate
    function automatic logic [23:0] tex_of(input logic [23:0] s, input logic [23:0] t);
        logic [31:0] h;
        h = (32'(s) * 32'h9E3779B1) ^ (32'(t) * 32'h85EBCA6B);
        h = h ^ (h >> 13);
        return h[23:0];
    endfunction

    // Reference filter: nearest returns texel 00, bilinear lerps per channel
    function automatic logic [23:0] ref_rgb(input logic [23:0] s, input logic [23:0] t,
                                            input logic [23:0] ds, input logic [23:0] dt,
                                            input logic [7:0] fs, input logic [7:0] ft,
                                            input logic bil);
        logic [23:0] c [4];
        logic [23:0] r;
        int a, b, e, d, top, bot, o;
        if (!bil) return tex_of(s, t);
        c[0] = tex_of(s, t);
        c[1] = tex_of(24'(s + ds), t);
        c[2] = tex_of(s, 24'(t + dt));
        c[3] = tex_of(24'(s + ds), 24'(t + dt));
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            a   = int'(c[0][ch*8 +: 8]);
            b   = int'(c[1][ch*8 +: 8]);
            e   = int'(c[2][ch*8 +: 8]);
            d   = int'(c[3][ch*8 +: 8]);
            top = (a * (256 - int'(fs)) + b * int'(fs)) / 256;
            bot = (e * (256 - int'(fs)) + d * int'(fs)) / 256;
            o   = (top * (256 - int'(ft)) + bot * int'(ft)) / 256;
            r[ch*8 +: 8] = 8'(o);
        end
        return r;
    endfunction

    // Cache responder: one texel per lookup after a configurable delay
    initial begin
        int d;
        int k;
        logic [23:0] cs, ct;
        resp_valid = 1'b0;
        resp_rgb   = '0;
        @(posedge clk); #1;
        forever begin
            if (tex_lkp_o === 1'b1) begin
                cs = tex_s_o;
                ct = tex_t_o;
                k  = lkp_s_q.size() - tbl_base;
                lkp_s_q.push_back(cs);
                lkp_t_q.push_back(ct);
                d = (cfg_delay == 0) ? int'($urandom_range(40, 1)) : cfg_delay;
                repeat (d) begin @(posedge clk); #1; end
                resp_rgb   = tbl_mode ? tbl[k & 3] : tex_of(cs, ct);
                resp_valid = 1'b1;
                @(posedge clk); #1;
                last_tv_cyc = cyc;
                resp_valid  = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    task automatic send_req(input logic [23:0] s, input logic [23:0] t,
                            input logic [23:0] ds, input logic [23:0] dt,
                            input logic [7:0] fs, input logic [7:0] ft,
                            input logic f, input logic [15:0] tag);
        int n = 0;
        req_s = s; req_t = t; req_ds = ds; req_dt = dt;
        req_fs = fs; req_ft = ft; req_filter = f; req_tag = tag;
        req_valid = 1'b1;
        while (req_ready_o !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        if (n >= 400) begin
            n_vec++; n_err++;
            $display("FAIL req_accept: req_ready_o stayed %b for %0d cycles, need 1", req_ready_o, n);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_frag(output int seen);
        int n = 0;
        @(negedge clk);
        while (frag_valid_o !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            n_vec++; n_err++;
            $display("FAIL frag_timeout: frag_valid_o=%b after %0d cycles, need 1", frag_valid_o, n);
        end
        seen = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready_in_reset: got %b need 1", req_ready_o); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (req_ready_o !== 1'b1)   begin n_err++; $display("FAIL rst_ready: got %b need 1", req_ready_o); end
        n_vec++; if (tex_lkp_o !== 1'b0)     begin n_err++; $display("FAIL rst_lkp: got %b need 0", tex_lkp_o); end
        n_vec++; if (frag_valid_o !== 1'b0)  begin n_err++; $display("FAIL rst_fvalid: got %b need 0", frag_valid_o); end
        n_vec++; if (tex_s_o !== 24'h0)      begin n_err++; $display("FAIL rst_tex_s: got %h need 0", tex_s_o); end
        n_vec++; if (tex_t_o !== 24'h0)      begin n_err++; $display("FAIL rst_tex_t: got %h need 0", tex_t_o); end
        n_vec++; if (frag_rgb_o !== 24'h0)   begin n_err++; $display("FAIL rst_rgb: got %h need 0", frag_rgb_o); end
        n_vec++; if (frag_tag_o !== 16'h0)   begin n_err++; $display("FAIL rst_tag: got %h need 0", frag_tag_o); end
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (tex_lkp_o !== 1'b0)     begin n_err++; $display("FAIL idle_lkp: got %b need 0", tex_lkp_o); end
    endtask

    task automatic test_nearest();
        int seen, base_l;
        tbl_mode = 1'b1; tbl[0] = 24'hAABBCC; tbl_base = lkp_s_q.size(); cfg_delay = 3;
        base_l = lkp_cnt;
        send_req(24'h100000, 24'h200000, 24'h0, 24'h0, 8'd0, 8'd0, 1'b0, 16'h0001);
        @(negedge clk);
        n_vec++; if (tex_lkp_o !== 1'b1)       begin n_err++; $display("FAIL near_lkp: got %b need 1", tex_lkp_o); end
        n_vec++; if (tex_s_o !== 24'h100000)   begin n_err++; $display("FAIL near_s: got %h need 100000", tex_s_o); end
        n_vec++; if (tex_t_o !== 24'h200000)   begin n_err++; $display("FAIL near_t: got %h need 200000", tex_t_o); end
        @(negedge clk);
        n_vec++; if (tex_lkp_o !== 1'b0)       begin n_err++; $display("FAIL near_lkp_pulse: got %b need 0", tex_lkp_o); end
        wait_frag(seen);
        n_vec++; if (frag_rgb_o !== 24'hAABBCC) begin n_err++; $display("FAIL near_rgb: got %h need aabbcc", frag_rgb_o); end
        n_vec++; if (frag_tag_o !== 16'h0001)   begin n_err++; $display("FAIL near_tag: got %h need 0001", frag_tag_o); end
        // frag_valid_o is up in the cycle that follows the tex_valid_i sampling edge
        n_vec++; if (seen - last_tv_cyc != 0)   begin n_err++; $display("FAIL near_latency: got %0d need 0 edges after texel", seen - last_tv_cyc); end
        n_vec++; if (lkp_cnt - base_l != 1)     begin n_err++; $display("FAIL near_nlkp: got %0d need 1", lkp_cnt - base_l); end
        @(posedge clk); #1;
    endtask

    task automatic test_bilinear();
        int seen, base_q, base_l;
        logic [23:0] es, et;
        tbl_mode = 1'b1; tbl_base = lkp_s_q.size(); cfg_delay = 5;
        tbl[0] = 24'h000000; tbl[1] = 24'hFF0000; tbl[2] = 24'h00FF00; tbl[3] = 24'h0000FF;
        base_q = lkp_s_q.size(); base_l = lkp_cnt;
        send_req(24'h100000, 24'h200000, 24'h000400, 24'h000800, 8'd128, 8'd128, 1'b1, 16'h0002);
        wait_frag(seen);
        n_vec++; if (frag_rgb_o !== 24'h3F3F3F) begin n_err++; $display("FAIL bil_rgb: got %h need 3f3f3f", frag_rgb_o); end
        n_vec++; if (frag_tag_o !== 16'h0002)   begin n_err++; $display("FAIL bil_tag: got %h need 0002", frag_tag_o); end
        // Third cycle after the last texel's sampling edge
        n_vec++; if (seen - last_tv_cyc != 2)   begin n_err++; $display("FAIL bil_latency: got %0d need 2 edges after texel", seen - last_tv_cyc); end
        n_vec++; if (lkp_cnt - base_l != 4)     begin n_err++; $display("FAIL bil_nlkp: got %0d need 4", lkp_cnt - base_l); end
        for (int i = 0; i < 4; i++) begin
            es = 24'h100000 + ((i % 2 == 1) ? 24'h000400 : 24'h0);
            et = 24'h200000 + ((i >= 2) ? 24'h000800 : 24'h0);
            n_vec++;
            if (lkp_s_q.size() <= base_q + i) begin
                n_err++; $display("FAIL bil_coord%0d: got no lookup need %h/%h", i, es, et);
            end else if (lkp_s_q[base_q+i] !== es || lkp_t_q[base_q+i] !== et) begin
                n_err++; $display("FAIL bil_coord%0d: got %h/%h need %h/%h", i, lkp_s_q[base_q+i], lkp_t_q[base_q+i], es, et);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wrap();
        int seen, base_q;
        tbl_mode = 1'b1; tbl_base = lkp_s_q.size(); cfg_delay = 2;
        tbl[0] = 24'h123456; tbl[1] = 24'hFFFFFF; tbl[2] = 24'hFFFFFF; tbl[3] = 24'hFFFFFF;
        base_q = lkp_s_q.size();
        send_req(24'hFFFFF0, 24'h000100, 24'h000020, 24'h000040, 8'd0, 8'd0, 1'b1, 16'h0003);
        wait_frag(seen);
        n_vec++; if (frag_rgb_o !== 24'h123456) begin n_err++; $display("FAIL zero_rgb: got %h need 123456", frag_rgb_o); end
        n_vec++;
        if (lkp_s_q.size() < base_q + 4) begin
            n_err++; $display("FAIL wrap_nlkp: got %0d need 4", lkp_s_q.size() - base_q);
        end else begin
            if (lkp_s_q[base_q+1] !== 24'h000010) begin n_err++; $display("FAIL wrap_s1: got %h need 000010", lkp_s_q[base_q+1]); end
            n_vec++; if (lkp_s_q[base_q+3] !== 24'h000010) begin n_err++; $display("FAIL wrap_s3: got %h need 000010", lkp_s_q[base_q+3]); end
            n_vec++; if (lkp_t_q[base_q+2] !== 24'h000140) begin n_err++; $display("FAIL wrap_t2: got %h need 000140", lkp_t_q[base_q+2]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int seen;
        logic [23:0] s1, t1, ds1, dt1, s2, t2, exp1;
        logic [7:0]  fs1, ft1;
        tbl_mode = 1'b0; cfg_delay = 2;
        s1 = 24'($urandom); t1 = 24'($urandom); ds1 = 24'($urandom); dt1 = 24'($urandom);
        fs1 = 8'($urandom); ft1 = 8'($urandom);
        exp1 = ref_rgb(s1, t1, ds1, dt1, fs1, ft1, 1'b1);
        frag_ready = 1'b0;
        send_req(s1, t1, ds1, dt1, fs1, ft1, 1'b1, 16'h0BAD);
        wait_frag(seen);
        s2 = 24'h0ABCDE; t2 = 24'h012345;
        req_s = s2; req_t = t2; req_ds = 24'h1; req_dt = 24'h1;
        req_fs = 8'd0; req_ft = 8'd0; req_filter = 1'b0; req_tag = 16'h0C0D;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            spur_valid = (i == 3);
            @(negedge clk);
            n_vec++; if (frag_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid%0d: got %b need 1", i, frag_valid_o); end
            n_vec++; if (frag_rgb_o !== exp1)   begin n_err++; $display("FAIL bp_rgb%0d: got %h need %h", i, frag_rgb_o, exp1); end
            n_vec++; if (frag_tag_o !== 16'h0BAD) begin n_err++; $display("FAIL bp_tag%0d: got %h need 0bad", i, frag_tag_o); end
            n_vec++; if (req_ready_o !== 1'b0)  begin n_err++; $display("FAIL bp_ready%0d: got %b need 0", i, req_ready_o); end
            n_vec++; if (tex_lkp_o !== 1'b0)    begin n_err++; $display("FAIL bp_lkp%0d: got %b need 0", i, tex_lkp_o); end
        end
        @(posedge clk); #1;
        spur_valid = 1'b0;
        frag_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if (req_ready_o !== 1'b1)  begin n_err++; $display("FAIL bp_release_ready: got %b need 1", req_ready_o); end
        n_vec++; if (frag_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b need 0", frag_valid_o); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (tex_lkp_o !== 1'b1)    begin n_err++; $display("FAIL bp_next_lkp: got %b need 1", tex_lkp_o); end
        n_vec++; if (tex_s_o !== s2)        begin n_err++; $display("FAIL bp_next_s: got %h need %h", tex_s_o, s2); end
        wait_frag(seen);
        n_vec++; if (frag_rgb_o !== tex_of(s2, t2)) begin n_err++; $display("FAIL bp_next_rgb: got %h need %h", frag_rgb_o, tex_of(s2, t2)); end
        n_vec++; if (frag_tag_o !== 16'h0C0D) begin n_err++; $display("FAIL bp_next_tag: got %h need 0c0d", frag_tag_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int seen, base_l, n, l_after;
        bit saw_valid;
        tbl_mode = 1'b0; cfg_delay = 12;
        base_l = lkp_cnt;
        send_req(24'h001000, 24'h002000, 24'h10, 24'h10, 8'd77, 8'd99, 1'b1, 16'h0EEE);
        n = 0;
        while (lkp_cnt - base_l < 3 && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (req_ready_o !== 1'b1)  begin n_err++; $display("FAIL arst_ready: got %b need 1", req_ready_o); end
        n_vec++; if (tex_lkp_o !== 1'b0)    begin n_err++; $display("FAIL arst_lkp: got %b need 0", tex_lkp_o); end
        n_vec++; if (frag_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_fvalid: got %b need 0", frag_valid_o); end
        n_vec++; if (tex_s_o !== 24'h0)     begin n_err++; $display("FAIL arst_tex_s: got %h need 0", tex_s_o); end
        n_vec++; if (tex_t_o !== 24'h0)     begin n_err++; $display("FAIL arst_tex_t: got %h need 0", tex_t_o); end
        n_vec++; if (frag_rgb_o !== 24'h0)  begin n_err++; $display("FAIL arst_rgb: got %h need 0", frag_rgb_o); end
        n_vec++; if (frag_tag_o !== 16'h0)  begin n_err++; $display("FAIL arst_tag: got %h need 0", frag_tag_o); end
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        l_after = lkp_cnt;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frag_valid_o !== 1'b0) saw_valid = 1'b1;
        end
        n_vec++; if (saw_valid)            begin n_err++; $display("FAIL arst_late_texel: frag_valid_o rose, need 0"); end
        n_vec++; if (lkp_cnt != l_after)   begin n_err++; $display("FAIL arst_late_lkp: got %0d lookups need 0", lkp_cnt - l_after); end
        cfg_delay = 3;
        send_req(24'h00AAAA, 24'h00BBBB, 24'h0, 24'h0, 8'd0, 8'd0, 1'b0, 16'h0F0F);
        wait_frag(seen);
        n_vec++; if (frag_rgb_o !== tex_of(24'h00AAAA, 24'h00BBBB)) begin n_err++; $display("FAIL arst_after_rgb: got %h need %h", frag_rgb_o, tex_of(24'h00AAAA, 24'h00BBBB)); end
        n_vec++; if (frag_tag_o !== 16'h0F0F) begin n_err++; $display("FAIL arst_after_tag: got %h need 0f0f", frag_tag_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_rgb_q[$];
        logic [15:0] exp_tag_q[$];
        logic [23:0] s, t, ds, dt, er;
        logic [15:0] et;
        logic [7:0]  fs, ft;
        logic        f;
        int seen, base_l, hold, sel;
        tbl_mode = 1'b0; cfg_delay = 0;
        for (int i = 0; i < 500; i++) begin
            s = 24'($urandom); t = 24'($urandom); ds = 24'($urandom); dt = 24'($urandom);
            sel = int'($urandom_range(5, 0));
            fs = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom);
            sel = int'($urandom_range(5, 0));
            ft = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom);
            f  = 1'($urandom);
            exp_rgb_q.push_back(ref_rgb(s, t, ds, dt, fs, ft, f));
            exp_tag_q.push_back(16'(i) + 16'h1000);
            base_l = lkp_cnt;
            send_req(s, t, ds, dt, fs, ft, f, 16'(i) + 16'h1000);
            wait_frag(seen);
            er = exp_rgb_q.pop_front();
            et = exp_tag_q.pop_front();
            n_vec++; if (frag_rgb_o !== er) begin n_err++; $display("FAIL rnd_rgb%0d: got %h need %h (filter %b fs %0d ft %0d)", i, frag_rgb_o, er, f, fs, ft); end
            n_vec++; if (frag_tag_o !== et) begin n_err++; $display("FAIL rnd_tag%0d: got %h need %h", i, frag_tag_o, et); end
            n_vec++; if (lkp_cnt - base_l != (f ? 4 : 1)) begin n_err++; $display("FAIL rnd_nlkp%0d: got %0d need %0d", i, lkp_cnt - base_l, f ? 4 : 1); end
            hold = int'($urandom_range(3, 0));
            if (hold > 0) begin
                frag_ready = 1'b0;
                repeat (hold) @(posedge clk);
                #1;
                frag_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; frag_ready = 1'b1; spur_valid = 1'b0;
        req_s = '0; req_t = '0; req_ds = '0; req_dt = '0;
        req_fs = '0; req_ft = '0; req_filter = 1'b0; req_tag = '0;
        test_reset();
        test_nearest();
        test_bilinear();
        test_zero_wrap();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
